muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Multi-cycle execution unit for the RV32M operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU). It replaces the single-cycle combinational multiply/divide path with a registered multiply and an iterative restoring divider. The core issues requests through a valid/ready handshake and stalls until the response is accepted. Integer ALU operations (op codes 0000–0111) never reach this block.

Parameters:
DIV_STEPS, 1, quotient bits resolved per clock in the divider. Legal values are 1, 2 and 4; other values are an elaboration error.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
flush  input  1  abort the in-flight operation (pipeline kill)
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_op  input  4  1000 MUL, 1001 DIV, 1010 DIVU, 1011 REM, 1100 REMU, 1101 MULH, 1110 MULHSU, 1111 MULHU
req_a  input  32  rs1 operand
req_b  input  32  rs2 operand
resp_valid  output  1  result available
resp_ready  input  1  consumer accepts result
resp_result  output  32  result
busy  output  1  state != IDLE

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous and active-low. While rst_n=0 at a rising edge: state=IDLE, resp_valid=0, resp_result=0, all internal operand/quotient/remainder/counter registers = 0.
- req_ready = (state==IDLE) && !flush. A request is accepted on an edge where req_valid && req_ready; operands and op are latched on that edge.
- req_op[3]=0 while req_valid=1 is illegal: the request is accepted, and the response is 0 after one cycle (IDLE→DONE).
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE→MUL on accept of ops 1000/1101/1110/1111.
- IDLE→DIV on accept of ops 1001–1100 with req_b≠0. Latched values: |a| and |b| (signed ops take the magnitude), neg_q = a[31]^b[31] (signed ops only), neg_r = a[31] (signed ops only), count = 32/DIV_STEPS.
- IDLE→DONE on accept of a divide/remainder op with req_b==0: result = 0.
- MUL→DONE after one cycle. The 64-bit product is signed×signed (1000, 1101), signed×unsigned (1110) or unsigned×unsigned (1111). Result is product[31:0] for MUL and product[63:32] for the others. The product is registered into resp_result on the MUL→DONE edge.
- DIV: each cycle performs DIV_STEPS restoring steps: shift remainder left by one and bring in the next dividend MSB; if remainder ≥ |b|, subtract and set quotient bit 1. count decrements by 1 per cycle. DIV→FIX when count reaches 1 at the edge.
- FIX→DONE after one cycle. resp_result = neg_q ? −quotient : quotient for DIV/DIVU, and neg_r ? −remainder : remainder for REM/REMU.
- Overflow (0x80000000 / 0xFFFFFFFF, DIV) gives 0x80000000 with no special case; REM of the same operands gives 0.
- DONE: resp_valid=1 and resp_result stays stable until resp_ready=1. Transition DONE→IDLE on the edge where resp_ready=1, with resp_valid=0 after that edge. A new request cannot be accepted in the same cycle as the response handshake, so accepts are back-to-back at best one cycle apart.
- Latency from accept edge to first resp_valid=1 cycle: MUL ops 2 edges; div/rem ops 32/DIV_STEPS+2 edges (34 when DIV_STEPS=1); divide by zero 1 edge.
- flush=1 at an edge in any state: state→IDLE and resp_valid→0, and the result is discarded. flush takes precedence over resp_ready, and no request is accepted in that cycle. A flush in IDLE has no effect.
- Reset mid-operation behaves as flush and additionally clears all registers.
- resp_result holds its last value outside DONE; consumers must qualify it with resp_valid.

Test Plan:
1. MUL a=0xFFFFFFFE, b=3 → resp 0xFFFFFFFA, resp_valid 2 edges after accept. MULH with the same operands → 0xFFFFFFFF. MULHU → 0x00000002. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
2. DIV a=−7 (0xFFFFFFF9), b=2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU 100/7 → 14, REMU 100/7 → 2. With DIV_STEPS=1, resp_valid appears exactly 34 edges after accept; rerun with DIV_STEPS=4 and check 10 edges.
3. DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM with the same operands → 0. DIVU 5/0 → 0 after 1 edge.
4. Hold resp_ready=0 for 5 cycles in DONE → resp_valid and resp_result stay stable and req_ready=0. Raise resp_ready → IDLE; the next request is accepted one cycle later.
5. Issue DIV, assert flush on cycle 10 → busy=0 next cycle and no resp_valid. A following MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE, uncorrupted.
6. Drive rst_n=0 for one edge mid-DIV → all outputs at reset values, req_ready=1 afterwards, and a subsequent REMU 9/4 → 1.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//    Multi-cycle RV32M execution unit. Multiplies take one registered cycle.
//    Divides and remainders use an iterative restoring divider that resolves
//    DIV_STEPS quotient bits per clock, followed by one sign-fixup cycle.
//    Requests and responses each use a valid/ready handshake.
//
// Ports
//    clk          rising-edge clock
//    rst_n        synchronous active-low reset
//    flush        abort any in-flight operation; the result is discarded
//    req_valid    request present
//    req_ready    block can accept a request (idle and not flushing)
//    req_op       1000 MUL, 1001 DIV, 1010 DIVU, 1011 REM, 1100 REMU,
//                 1101 MULH, 1110 MULHSU, 1111 MULHU (op[3]=0 returns 0)
//    req_a/req_b  rs1 / rs2 operands
//    resp_valid   result available
//    resp_ready   consumer accepts result
//    resp_result  result (hold value outside DONE; qualify with resp_valid)
//    busy         any state other than IDLE
module muldiv_sequencer #(
   parameter int DIV_STEPS = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_result,
   output logic        busy
);

   generate
      if (DIV_STEPS != 1 && DIV_STEPS != 2 && DIV_STEPS != 4) begin : g_bad_div_steps
         $error("muldiv_sequencer: DIV_STEPS must be 1, 2 or 4");
      end
   endgenerate

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_MUL  = 3'd1;
   localparam logic [2:0] ST_DIV  = 3'd2;
   localparam logic [2:0] ST_FIX  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   localparam logic [3:0] OP_MUL    = 4'b1000;
   localparam logic [3:0] OP_DIV    = 4'b1001;
   localparam logic [3:0] OP_DIVU   = 4'b1010;
   localparam logic [3:0] OP_REM    = 4'b1011;
   localparam logic [3:0] OP_MULH   = 4'b1101;
   localparam logic [3:0] OP_MULHSU = 4'b1110;
   localparam logic [3:0] OP_MULHU  = 4'b1111;

   // Number of DIV-state cycles needed to resolve all 32 quotient bits.
   localparam logic [5:0] DIV_CYCLES = 6'(32 / DIV_STEPS);

   logic [2:0]  state_reg, state_next;
   logic [3:0]  op_reg, op_next;
   // a_reg: multiplicand, or dividend magnitude shifted out MSB first.
   // b_reg: multiplier, or divisor magnitude.
   logic [31:0] a_reg, a_next;
   logic [31:0] b_reg, b_next;
   logic [31:0] quotient_reg, quotient_next;
   logic [31:0] remainder_reg, remainder_next;
   logic [5:0]  count_reg, count_next;
   logic        neg_q_reg, neg_q_next;
   logic        neg_r_reg, neg_r_next;
   logic [31:0] resp_result_reg, resp_result_next;

   // ------------------------------------------------------------------
   // Request decode
   // ------------------------------------------------------------------
   logic        req_is_mul;
   logic        req_div_signed;
   logic [31:0] req_a_mag;
   logic [31:0] req_b_mag;

   assign req_is_mul = (req_op == OP_MUL) || (req_op == OP_MULH) ||
                       (req_op == OP_MULHSU) || (req_op == OP_MULHU);
   assign req_div_signed = (req_op == OP_DIV) || (req_op == OP_REM);
   // 0x80000000 maps to itself, which is the correct unsigned magnitude.
   assign req_a_mag = (req_div_signed && req_a[31]) ? (~req_a + 32'd1) : req_a;
   assign req_b_mag = (req_div_signed && req_b[31]) ? (~req_b + 32'd1) : req_b;

   // ------------------------------------------------------------------
   // Multiplier: operands extended to 64 bits according to op, then a
   // modular 64x64 multiply gives the exact product in the low 64 bits.
   // ------------------------------------------------------------------
   logic        mul_a_sext;
   logic        mul_b_sext;
   logic [63:0] mul_a_ext;
   logic [63:0] mul_b_ext;
   logic [63:0] product;

   assign mul_a_sext = (op_reg != OP_MULHU) && a_reg[31];
   assign mul_b_sext = ((op_reg == OP_MUL) || (op_reg == OP_MULH)) && b_reg[31];
   assign mul_a_ext  = {{32{mul_a_sext}}, a_reg};
   assign mul_b_ext  = {{32{mul_b_sext}}, b_reg};
   assign product    = mul_a_ext * mul_b_ext;

   // ------------------------------------------------------------------
   // Restoring divider: DIV_STEPS chained steps per clock.
   // ------------------------------------------------------------------
   logic [31:0] rem_chain [0:DIV_STEPS];
   logic [31:0] dvd_chain [0:DIV_STEPS];
   logic [31:0] quo_chain [0:DIV_STEPS];

   assign rem_chain[0] = remainder_reg;
   assign dvd_chain[0] = a_reg;
   assign quo_chain[0] = quotient_reg;

   genvar gi;
   generate
      for (gi = 0; gi < DIV_STEPS; gi++) begin : g_div_step
         logic [32:0] shifted;
         logic [32:0] diff;
         // Partial remainder stays below the divisor, so the shifted value
         // fits in 33 bits and diff[32] is set exactly when shifted < divisor.
         assign shifted = {rem_chain[gi], dvd_chain[gi][31]};
         assign diff    = shifted - {1'b0, b_reg};
         assign rem_chain[gi+1] = diff[32] ? shifted[31:0] : diff[31:0];
         assign dvd_chain[gi+1] = {dvd_chain[gi][30:0], 1'b0};
         assign quo_chain[gi+1] = {quo_chain[gi][30:0], ~diff[32]};
      end
   endgenerate

   // Sign fixup applied in FIX.
   logic [31:0] quotient_fixed;
   logic [31:0] remainder_fixed;
   logic [31:0] fix_result;

   assign quotient_fixed  = neg_q_reg ? (~quotient_reg + 32'd1) : quotient_reg;
   assign remainder_fixed = neg_r_reg ? (~remainder_reg + 32'd1) : remainder_reg;
   assign fix_result = ((op_reg == OP_DIV) || (op_reg == OP_DIVU)) ?
                       quotient_fixed : remainder_fixed;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next       = state_reg;
      op_next          = op_reg;
      a_next           = a_reg;
      b_next           = b_reg;
      quotient_next    = quotient_reg;
      remainder_next   = remainder_reg;
      count_next       = count_reg;
      neg_q_next       = neg_q_reg;
      neg_r_next       = neg_r_reg;
      resp_result_next = resp_result_reg;

      if (flush) begin
         // Kill wins over everything, including a pending response handshake.
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (req_valid) begin
                  op_next = req_op;
                  if (!req_op[3]) begin
                     // Integer ALU op routed here by mistake: answer 0.
                     resp_result_next = 32'd0;
                     state_next       = ST_DONE;
                  end else if (req_is_mul) begin
                     a_next     = req_a;
                     b_next     = req_b;
                     state_next = ST_MUL;
                  end else if (req_b == 32'd0) begin
                     resp_result_next = 32'd0;
                     state_next       = ST_DONE;
                  end else begin
                     a_next         = req_a_mag;
                     b_next         = req_b_mag;
                     quotient_next  = 32'd0;
                     remainder_next = 32'd0;
                     count_next     = DIV_CYCLES;
                     neg_q_next     = req_div_signed && (req_a[31] ^ req_b[31]);
                     neg_r_next     = req_div_signed && req_a[31];
                     state_next     = ST_DIV;
                  end
               end
            end
            ST_MUL: begin
               resp_result_next = (op_reg == OP_MUL) ? product[31:0] : product[63:32];
               state_next       = ST_DONE;
            end
            ST_DIV: begin
               remainder_next = rem_chain[DIV_STEPS];
               a_next         = dvd_chain[DIV_STEPS];
               quotient_next  = quo_chain[DIV_STEPS];
               count_next     = count_reg - 6'd1;
               if (count_reg == 6'd1) begin
                  state_next = ST_FIX;
               end
            end
            ST_FIX: begin
               resp_result_next = fix_result;
               state_next       = ST_DONE;
            end
            ST_DONE: begin
               if (resp_ready) begin
                  state_next = ST_IDLE;
               end
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg       <= ST_IDLE;
         op_reg          <= 4'd0;
         a_reg           <= 32'd0;
         b_reg           <= 32'd0;
         quotient_reg    <= 32'd0;
         remainder_reg   <= 32'd0;
         count_reg       <= 6'd0;
         neg_q_reg       <= 1'b0;
         neg_r_reg       <= 1'b0;
         resp_result_reg <= 32'd0;
      end else begin
         state_reg       <= state_next;
         op_reg          <= op_next;
         a_reg           <= a_next;
         b_reg           <= b_next;
         quotient_reg    <= quotient_next;
         remainder_reg   <= remainder_next;
         count_reg       <= count_next;
         neg_q_reg       <= neg_q_next;
         neg_r_reg       <= neg_r_next;
         resp_result_reg <= resp_result_next;
      end
   end

   assign req_ready   = (state_reg == ST_IDLE) && !flush;
   assign resp_valid  = (state_reg == ST_DONE);
   assign resp_result = resp_result_reg;
   assign busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//    Randomized and directed checks of muldiv_sequencer against a plain
//    arithmetic reference model. Two instances share operand inputs: one
//    with DIV_STEPS=1 and one with DIV_STEPS=4, each with its own req_valid.
module tb_muldiv_sequencer;

   localparam logic [3:0] OP_MUL    = 4'b1000;
   localparam logic [3:0] OP_DIV    = 4'b1001;
   localparam logic [3:0] OP_DIVU   = 4'b1010;
   localparam logic [3:0] OP_REM    = 4'b1011;
   localparam logic [3:0] OP_REMU   = 4'b1100;
   localparam logic [3:0] OP_MULH   = 4'b1101;
   localparam logic [3:0] OP_MULHSU = 4'b1110;
   localparam logic [3:0] OP_MULHU  = 4'b1111;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        flush;
   logic        req_valid1, req_valid4;
   logic        resp_ready;
   logic [3:0]  req_op;
   logic [31:0] req_a, req_b;

   logic        req_ready1, resp_valid1, busy1;
   logic [31:0] resp_result1;
   logic        req_ready4, resp_valid4, busy4;
   logic [31:0] resp_result4;

   logic        sel4 = 1'b0;
   wire         obs_ready  = sel4 ? req_ready4 : req_ready1;
   wire         obs_valid  = sel4 ? resp_valid4 : resp_valid1;
   wire  [31:0] obs_result = sel4 ? resp_result4 : resp_result1;

   int n_tests = 0;
   int n_fail  = 0;

   muldiv_sequencer #(.DIV_STEPS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .req_valid(req_valid1), .req_ready(req_ready1),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .resp_valid(resp_valid1), .resp_ready(resp_ready),
      .resp_result(resp_result1), .busy(busy1)
   );

   muldiv_sequencer #(.DIV_STEPS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .req_valid(req_valid4), .req_ready(req_ready4),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .resp_valid(resp_valid4), .resp_ready(resp_ready),
      .resp_result(resp_result4), .busy(busy4)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // RV32M semantics from plain 64-bit arithmetic; divide by zero yields 0.
   function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      ua = longint'(a);
      ub = longint'(b);
      p  = 64'd0;
      case (op)
         OP_MUL:    begin p = sa * sb; return p[31:0];  end
         OP_MULH:   begin p = sa * sb; return p[63:32]; end
         OP_MULHSU: begin p = sa * ub; return p[63:32]; end
         OP_MULHU:  begin p = ua * ub; return p[63:32]; end
         OP_DIV:    return (b == 0) ? 32'd0 : 32'(sa / sb);
         OP_REM:    return (b == 0) ? 32'd0 : 32'(sa % sb);
         OP_DIVU:   return (b == 0) ? 32'd0 : 32'(ua / ub);
         OP_REMU:   return (b == 0) ? 32'd0 : 32'(ua % ub);
         default:   return 32'd0;
      endcase
   endfunction

   // Edges from the accept edge (counted as 1) to the first resp_valid cycle.
   function automatic int exp_latency(input logic [3:0] op, input logic [31:0] b,
                                      input int steps);
      if (!op[3]) return 1;
      if (op == OP_MUL || op == OP_MULH || op == OP_MULHSU || op == OP_MULHU) return 2;
      if (b == 0) return 1;
      return 32 / steps + 2;
   endfunction

   task automatic run_op(input logic use4, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
      logic [31:0] res;
      int          lat;
      int          steps;
      steps = use4 ? 4 : 1;
      sel4  = use4;
      @(negedge clk);
      req_op     = op;
      req_a      = a;
      req_b      = b;
      resp_ready = 1'b0;
      if (use4) req_valid4 = 1'b1;
      else      req_valid1 = 1'b1;
      #1;
      check_val("req_ready", {31'd0, obs_ready}, 32'd1);
      @(posedge clk);
      #1;
      req_valid1 = 1'b0;
      req_valid4 = 1'b0;
      lat = 1;
      while (obs_valid !== 1'b1 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      res = obs_result;
      check_val("result", res, model(op, a, b));
      check_val("latency", 32'(lat), 32'(exp_latency(op, b, steps)));
      $display("[TB] steps=%0d op=%b a=%h b=%h result=%h latency=%0d",
               steps, op, a, b, res, lat);
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      check_val("resp_drop", {31'd0, obs_valid}, 32'd0);
   endtask

   function automatic logic [31:0] rand_operand();
      logic [31:0] edge_vals [5];
      edge_vals = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
      case ($urandom_range(0, 3))
         0:       return 32'($urandom_range(0, 20));
         1:       return edge_vals[$urandom_range(0, 4)];
         2:       return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [3:0] rand_op();
      if ($urandom_range(0, 9) == 0) return 4'($urandom_range(0, 7));
      return 4'($urandom_range(8, 15));
   endfunction

   logic [3:0]  dir_op [12];
   logic [31:0] dir_a  [12];
   logic [31:0] dir_b  [12];
   logic        seen;
   int          cyc;

   initial begin
      rst_n      = 1'b0;
      flush      = 1'b0;
      req_valid1 = 1'b0;
      req_valid4 = 1'b0;
      resp_ready = 1'b0;
      req_op     = 4'd0;
      req_a      = 32'd0;
      req_b      = 32'd0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_valid1", {31'd0, resp_valid1}, 32'd0);
      check_val("rst_result1", resp_result1, 32'd0);
      check_val("rst_busy1", {31'd0, busy1}, 32'd0);
      check_val("rst_ready1", {31'd0, req_ready1}, 32'd1);
      check_val("rst_ready4", {31'd0, req_ready4}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed operand table
      dir_op = '{OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU, OP_DIV, OP_REM,
                 OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIVU, OP_DIV};
      dir_a  = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF,
                 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                 32'h80000000, 32'h80000000, 32'd5, 32'h0000_0007};
      dir_b  = '{32'd3, 32'd3, 32'd3, 32'hFFFFFFFF,
                 32'd2, 32'd2, 32'd7, 32'd7,
                 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFE};
      for (int i = 0; i < 12; i++) run_op(1'b0, dir_op[i], dir_a[i], dir_b[i]);
      // Same divide on the 4-step instance: 10-edge latency
      run_op(1'b1, OP_DIV, 32'hFFFFFFF9, 32'd2);
      run_op(1'b1, OP_REMU, 32'd100, 32'd7);
      run_op(1'b0, 4'b0011, 32'd5, 32'd6);

      // Randomized traffic on both instances
      for (int i = 0; i < 40; i++) run_op(1'b0, rand_op(), rand_operand(), rand_operand());
      for (int i = 0; i < 20; i++) run_op(1'b1, rand_op(), rand_operand(), rand_operand());

      // Back-pressure: hold resp_ready low in DONE
      sel4 = 1'b0;
      @(negedge clk);
      req_op = OP_DIVU; req_a = 32'd100; req_b = 32'd7; req_valid1 = 1'b1;
      @(posedge clk);
      #1;
      req_valid1 = 1'b0;
      cyc = 0;
      while (resp_valid1 !== 1'b1 && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check_val("hold_seen", {31'd0, resp_valid1}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check_val("hold_valid", {31'd0, resp_valid1}, 32'd1);
         check_val("hold_result", resp_result1, 32'd14);
         check_val("hold_ready", {31'd0, req_ready1}, 32'd0);
      end
      @(negedge clk);
      resp_ready = 1'b1;
      req_op = OP_MUL; req_a = 32'd6; req_b = 32'd7; req_valid1 = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      check_val("hs_valid_drop", {31'd0, resp_valid1}, 32'd0);
      check_val("hs_no_accept", {31'd0, busy1}, 32'd0);
      check_val("hs_ready_back", {31'd0, req_ready1}, 32'd1);
      @(posedge clk);
      #1;
      req_valid1 = 1'b0;
      check_val("hs_accept_next", {31'd0, busy1}, 32'd1);
      @(posedge clk);
      #1;
      check_val("hs_mul_valid", {31'd0, resp_valid1}, 32'd1);
      check_val("hs_mul_result", resp_result1, 32'd42);
      $display("[TB] backpressure DIVU 100/7 held 5 cycles, then MUL 6*7=%h", resp_result1);
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;

      // Flush on cycle 10 of a DIV
      @(negedge clk);
      req_op = OP_DIV; req_a = 32'h12345678; req_b = 32'd3; req_valid1 = 1'b1;
      @(posedge clk);
      #1;
      req_valid1 = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check_val("flush_busy_before", {31'd0, busy1}, 32'd1);
      @(negedge clk);
      flush = 1'b1;
      req_op = OP_MUL; req_valid1 = 1'b1;
      #1;
      check_val("flush_ready", {31'd0, req_ready1}, 32'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      req_valid1 = 1'b0;
      check_val("flush_busy", {31'd0, busy1}, 32'd0);
      check_val("flush_valid", {31'd0, resp_valid1}, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (resp_valid1 || busy1) seen = 1'b1;
      end
      check_val("flush_quiet", {31'd0, seen}, 32'd0);
      $display("[TB] flush of DIV on cycle 10 observed busy=%b", busy1);
      run_op(1'b0, OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);

      // Reset mid-DIV
      sel4 = 1'b0;
      @(negedge clk);
      req_op = OP_DIV; req_a = 32'h7654321; req_b = 32'd5; req_valid1 = 1'b1;
      @(posedge clk);
      #1;
      req_valid1 = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_val("mrst_valid", {31'd0, resp_valid1}, 32'd0);
      check_val("mrst_result1", resp_result1, 32'd0);
      check_val("mrst_result4", resp_result4, 32'd0);
      check_val("mrst_busy", {31'd0, busy1}, 32'd0);
      check_val("mrst_ready", {31'd0, req_ready1}, 32'd1);
      $display("[TB] reset mid-DIV: busy=%b result=%h", busy1, resp_result1);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(1'b0, OP_REMU, 32'd9, 32'd4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
